cricket_tracker: RTL and testbench
==================================

# cricket_tracker

Scoreboard engine for one cricket innings. It counts legal deliveries into balls and overs, accumulates runs and wickets, and runs a three-state innings FSM (idle, in play, over). It sits between the ball-event decoder upstream and the scoreboard display / match-control logic downstream. All outputs are registered state, readable at any time.

## Interface
- MAX_OVERS, default 20: overs per innings (1..31, must fit `overs`).
- MAX_WICKETS, default 10: wickets that end the innings (1..15).
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start_innings  input  1  one-cycle request to begin a new innings.
- ball_bowled  input  1  one-cycle strobe: a legal delivery completed this cycle.
- runs_scored  input  3  runs off this delivery (0..7), valid with ball_bowled.
- wicket_fallen  input  1  wicket on this delivery, valid with ball_bowled.
- balls  output  3  balls bowled in the current over, 0..5.
- overs  output  5  completed overs, 0..MAX_OVERS.
- total_runs  output  16  innings run total.
- wickets  output  4  wickets fallen, 0..MAX_WICKETS.
- game_state  output  2  0 = IDLE, 1 = IN_PLAY, 2 = INNINGS_OVER; 3 is unused.
- innings_active  output  1  high exactly when game_state = IN_PLAY.

## Operation
- On reset, every output is 0 and the state is IDLE.
- **IDLE or INNINGS_OVER, start_innings = 1:**
  - Clear balls, overs, total_runs and wickets.
  - Go to IN_PLAY.
  - A ball_bowled in the same cycle is ignored.
- **IN_PLAY, start_innings = 1:** ignored.
- **IN_PLAY, ball_bowled = 1 (one delivery per cycle in which it is high):**
  - total_runs += runs_scored. Saturates at 16'hFFFF.
  - If wicket_fallen, wickets += 1. Runs and wicket on the same ball both count.
  - If balls < 5, balls += 1. Otherwise balls becomes 0 and overs += 1.
- **ball_bowled outside IN_PLAY:** no counter changes.
- **End of innings:** after a delivery is applied, go to INNINGS_OVER if either holds:
  - wickets reaches MAX_WICKETS;
  - overs reaches MAX_OVERS (balls = 0).
- INNINGS_OVER holds all counters frozen until start_innings or reset.
- runs_scored and wicket_fallen are don't-care when ball_bowled is low.

## Timing
- Updates are synchronous to clk. Results are visible right after the sampling edge, i.e. one cycle of latency from strobe to output.
- Deliveries on consecutive cycles are each counted. There is no backpressure or handshake.
- The transition into INNINGS_OVER happens on the same edge as the final delivery's counter update.
- innings_active is decoded from the state register and has no extra delay.
- Reset asserted mid-innings clears everything asynchronously. After release the block waits in IDLE for start_innings.

## Structure
- Shared package `cricket_pkg`:
  - game-state enum (IDLE, IN_PLAY, INNINGS_OVER);
  - BALLS_PER_OVER = 6;
  - default MAX_OVERS and MAX_WICKETS.
- One natural sub-module, `ball_over_counter`:
  - contains the balls 0..5 wrap logic and the overs increment;
  - has enable and clear inputs and raises an over-complete flag.
- Runs, wickets and the FSM live in the top level.

## Test plan
- Reset, then start_innings. Bowl (1,0),(0,0),(4,0),(2,0),(0,W),(6,0) → after each ball: 0.1 1/0, 0.2 1/0, 0.3 5/0, 0.4 7/0, 0.5 7/1, 1.0 13/1.
- Continue with over 2 (3,1,4,0,2,6, no wickets) and over 3 (1,1,0W,4,6,2) → 2.0 29/1, then final 3.0 43/2. game_state = 1 and innings_active = 1 throughout.
- 10 consecutive wicket balls → wickets = 10, game_state = 2, innings_active = 0. An 11th ball_bowled changes nothing.
- MAX_OVERS = 2, bowl 12 balls of 1 run → overs = 2, balls = 0, total_runs = 12, state INNINGS_OVER. Then start_innings → all counters 0, state IN_PLAY.
- ball_bowled while IDLE, and start_innings mid-innings → no effect. Reset asserted mid-over → all outputs 0 immediately, state IDLE.
- Simultaneous start_innings and ball_bowled in IDLE → IN_PLAY with all counters 0. runs_scored = 7 on one ball → total_runs += 7.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket innings scoreboard.
// Imported by the ball/over counter and the top level.
package cricket_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    IN_PLAY      = 2'd1,
    INNINGS_OVER = 2'd2
  } game_state_e;

  localparam int unsigned BALLS_PER_OVER  = 6;
  localparam int unsigned DEF_MAX_OVERS   = 20;
  localparam int unsigned DEF_MAX_WICKETS = 10;

endpackage

// File: rtl/ball_over_counter.sv
// Legal-delivery counter: balls 0..5 within the over, completed overs.
// over_done_o flags the delivery that completes the current over.
module ball_over_counter
  import cricket_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [2:0] balls_o,
  output logic [4:0] overs_o,
  output logic       over_done_o
);

  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);

  logic [2:0] balls_q, balls_d;
  logic [4:0] overs_q, overs_d;

  assign over_done_o = en_i && (balls_q == LAST_BALL);

  // Next-state: clear wins over a delivery; sixth ball wraps into overs.
  always_comb begin
    balls_d = balls_q;
    overs_d = overs_q;
    if (clr_i) begin
      balls_d = '0;
      overs_d = '0;
    end else if (en_i) begin
      if (balls_q == LAST_BALL) begin
        balls_d = '0;
        overs_d = overs_q + 5'd1;
      end else begin
        balls_d = balls_q + 3'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balls_q <= '0;
      overs_q <= '0;
    end else begin
      balls_q <= balls_d;
      overs_q <= overs_d;
    end
  end

  assign balls_o = balls_q;
  assign overs_o = overs_q;

endmodule

// File: rtl/cricket_tracker.sv
// Innings scoreboard: runs, wickets and the idle/in-play/over FSM.
// Ball and over counting is delegated to ball_over_counter.
module cricket_tracker
  import cricket_pkg::*;
#(
  parameter int unsigned MAX_OVERS   = DEF_MAX_OVERS,
  parameter int unsigned MAX_WICKETS = DEF_MAX_WICKETS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_innings,
  input  logic        ball_bowled,
  input  logic [2:0]  runs_scored,
  input  logic        wicket_fallen,
  output logic [2:0]  balls,
  output logic [4:0]  overs,
  output logic [15:0] total_runs,
  output logic [3:0]  wickets,
  output logic [1:0]  game_state,
  output logic        innings_active
);

  localparam logic [4:0] MAX_O = 5'(MAX_OVERS);
  localparam logic [3:0] MAX_W = 4'(MAX_WICKETS);

  game_state_e state_q, state_d;
  logic [15:0] runs_q, runs_d;
  logic [3:0]  wkts_q, wkts_d;
  logic [16:0] run_sum;
  logic        in_play, start, deliver;
  logic        over_done;
  logic        last_over;

  assign in_play = (state_q == IN_PLAY);
  assign start   = start_innings && !in_play;
  assign deliver = ball_bowled && in_play;

  ball_over_counter u_bo (
    .clk        (clk),
    .reset      (reset),
    .en_i       (deliver),
    .clr_i      (start),
    .balls_o    (balls),
    .overs_o    (overs),
    .over_done_o(over_done)
  );

  assign run_sum   = {1'b0, runs_q} + {14'd0, runs_scored};
  assign last_over = over_done && ((overs + 5'd1) == MAX_O);

  // Next-state for runs, wickets and innings state.
  always_comb begin
    runs_d  = runs_q;
    wkts_d  = wkts_q;
    state_d = state_q;
    unique case (1'b1)
      start: begin
        runs_d  = '0;
        wkts_d  = '0;
        state_d = IN_PLAY;
      end
      deliver: begin
        runs_d = run_sum[16] ? 16'hFFFF : run_sum[15:0];
        if (wicket_fallen) wkts_d = wkts_q + 4'd1;
        if (wkts_d == MAX_W || last_over) state_d = INNINGS_OVER;
      end
      default: ;
    endcase
  end

  // State and score registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      runs_q  <= '0;
      wkts_q  <= '0;
    end else begin
      state_q <= state_d;
      runs_q  <= runs_d;
      wkts_q  <= wkts_d;
    end
  end

  assign total_runs     = runs_q;
  assign wickets        = wkts_q;
  assign game_state     = state_q;
  assign innings_active = in_play;

endmodule

// File: tb/tb_cricket_tracker.sv
// Directed bench for cricket_tracker: default instance plus a
// two-over instance sharing stimulus.
module tb_cricket_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_innings = 1'b0;
  logic        ball_bowled = 1'b0;
  logic [2:0]  runs_scored = '0;
  logic        wicket_fallen = 1'b0;

  logic [2:0]  balls, balls2;
  logic [4:0]  overs, overs2;
  logic [15:0] total_runs, total_runs2;
  logic [3:0]  wickets, wickets2;
  logic [1:0]  game_state, game_state2;
  logic        innings_active, innings_active2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cricket_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .start_innings (start_innings),
    .ball_bowled   (ball_bowled),
    .runs_scored   (runs_scored),
    .wicket_fallen (wicket_fallen),
    .balls         (balls),
    .overs         (overs),
    .total_runs    (total_runs),
    .wickets       (wickets),
    .game_state    (game_state),
    .innings_active(innings_active)
  );

  cricket_tracker #(.MAX_OVERS(2)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .start_innings (start_innings),
    .ball_bowled   (ball_bowled),
    .runs_scored   (runs_scored),
    .wicket_fallen (wicket_fallen),
    .balls         (balls2),
    .overs         (overs2),
    .total_runs    (total_runs2),
    .wickets       (wickets2),
    .game_state    (game_state2),
    .innings_active(innings_active2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int b, input int o,
                      input int r, input int w, input int st);
    chk({tag, ".balls"}, 32'(balls), b);
    chk({tag, ".overs"}, 32'(overs), o);
    chk({tag, ".runs"}, 32'(total_runs), r);
    chk({tag, ".wkts"}, 32'(wickets), w);
    chk({tag, ".state"}, 32'(game_state), st);
    chk({tag, ".active"}, 32'(innings_active), (st == 1) ? 1 : 0);
  endtask

  task automatic chk2(input string tag, input int b, input int o,
                      input int r, input int w, input int st);
    chk({tag, ".balls2"}, 32'(balls2), b);
    chk({tag, ".overs2"}, 32'(overs2), o);
    chk({tag, ".runs2"}, 32'(total_runs2), r);
    chk({tag, ".wkts2"}, 32'(wickets2), w);
    chk({tag, ".state2"}, 32'(game_state2), st);
    chk({tag, ".active2"}, 32'(innings_active2), (st == 1) ? 1 : 0);
  endtask

  // Apply inputs at a falling edge; return at the next falling edge.
  task automatic step(input logic st, input logic bb,
                      input int r, input logic w);
    start_innings = st;
    ball_bowled   = bb;
    runs_scored   = 3'(r);
    wicket_fallen = w;
    @(negedge clk);
    start_innings = 1'b0;
    ball_bowled   = 1'b0;
    runs_scored   = '0;
    wicket_fallen = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int o1r[6] = '{1, 0, 4, 2, 0, 6};
  bit o1w[6] = '{0, 0, 0, 0, 1, 0};
  int o1t[6] = '{1, 1, 5, 7, 7, 13};
  int o2r[6] = '{3, 1, 4, 0, 2, 6};
  int o3r[6] = '{1, 1, 0, 4, 6, 2};
  bit o3w[6] = '{0, 0, 1, 0, 0, 0};

  initial begin
    int tot;
    int wk;
    @(negedge clk);
    @(negedge clk);
    chk1("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    step(0, 1, 5, 1);
    chk1("idle_ball", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0);
    chk1("start", 0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      step(0, 1, o1r[i], o1w[i]);
      chk1($sformatf("ov1_b%0d", i), (i + 1) % 6, (i == 5) ? 1 : 0,
           o1t[i], (i >= 4) ? 1 : 0, 1);
    end
    tot = 13;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, o2r[i], 0);
      tot += o2r[i];
    end
    chk1("ov2_end", 0, 2, 29, 1, 1);
    chk("ov2_tot", 32'(total_runs), tot);
    wk = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, o3r[i], o3w[i]);
      if (i == 2) chk1("ov3_b3", 3, 2, 31, 2, 1);
    end
    chk1("ov3_end", 0, 3, 43, 2, 1);

    step(1, 0, 0, 0);
    chk1("mid_start", 0, 3, 43, 2, 1);

    step(0, 1, 2, 0);
    step(0, 1, 3, 0);
    #2 reset = 1'b1;
    #1;
    chk1("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst", 0, 0, 0, 0, 0);

    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1);
      if (i == 8) chk1("wk9", 3, 1, 0, 9, 1);
    end
    chk1("wk10", 4, 1, 0, 10, 2);
    step(0, 1, 4, 1);
    chk1("wk11", 4, 1, 0, 10, 2);

    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 1, 0);
    chk2("mo_b11", 5, 1, 11, 0, 1);
    step(0, 1, 1, 0);
    chk2("mo_b12", 0, 2, 12, 0, 2);
    step(0, 1, 3, 1);
    chk2("mo_frozen", 0, 2, 12, 0, 2);
    step(1, 0, 0, 0);
    chk2("mo_restart", 0, 0, 0, 0, 1);

    do_reset();
    step(1, 1, 3, 1);
    chk1("start_ball", 0, 0, 0, 0, 1);
    step(0, 1, 7, 0);
    chk1("run7", 1, 0, 7, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
